// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: debounces a raw push-button and issues a single one-cycle
// toggle request (t) for every accepted press, plus a debounced level and a
// wrapping count of issued pulses.
// Optional feature: define TOGGLE_PULSE_GEN_SYNC_EN to put a second flop in
// front of the sample register (2-flop synchronizer, one extra cycle latency).
module toggle_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       t,
  output logic       stable,
  output logic [7:0] pulse_count
);

  // Terminal value of the debounce counter; cnt never goes past it.
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       s_q;
  logic       t_q, t_d;
  logic       stable_q, stable_d;
  logic [7:0] pulse_count_q, pulse_count_d;

`ifdef TOGGLE_PULSE_GEN_SYNC_EN
  logic sync_q;

  // Two-flop synchronizer: btn -> sync_q -> s_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= btn;
      s_q    <= sync_q;
    end
  end
`else
  // Single sample register; the only path from btn into the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= 1'b0;
    end else begin
      s_q <= btn;
    end
  end
`endif

  // Debounce FSM next state, counter and pulse generation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    t_d           = 1'b0;
    pulse_count_d = pulse_count_q;
    case (state_q)
      ST_LOW: begin
        if (s_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_WAIT_HIGH: begin
        if (!s_q) begin
          // Bounce: abandon the pending press.
          state_d = ST_LOW;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_MAX) begin
          state_d       = ST_HIGH;
          cnt_d         = 8'd0;
          t_d           = 1'b1;
          pulse_count_d = pulse_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (!s_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_WAIT_LOW: begin
        if (s_q) begin
          // Bounce: abandon the pending release.
          state_d = ST_HIGH;
          cnt_d   = 8'd0;
        end else if (cnt_q == CNT_MAX) begin
          // Release is accepted silently; no toggle request.
          state_d = ST_LOW;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = 8'd0;
      end
    endcase
    // Registered level tracks the state being entered, so it changes with it.
    stable_d = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_LOW;
      cnt_q         <= 8'd0;
      t_q           <= 1'b0;
      stable_q      <= 1'b0;
      pulse_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      t_q           <= t_d;
      stable_q      <= stable_d;
      pulse_count_q <= pulse_count_d;
    end
  end

  assign t           = t_q;
  assign stable      = stable_q;
  assign pulse_count = pulse_count_q;

endmodule
